// File: rtl/shift_serializer.sv
// MSB-first parallel-to-serial shifter with one-cycle end-of-frame load strobe.
// Optional parity output when SHIFT_SERIALIZER_PARITY_EN is defined.
module shift_serializer #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             shift_out,
    output logic             load_out,
    output logic             busy,
`ifdef SHIFT_SERIALIZER_PARITY_EN
    output logic             parity_out,
`endif
    output logic [15:0]      frame_count
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             shift_out_q, shift_out_d;
    logic             load_out_q, load_out_d;
    logic             busy_q, busy_d;
    logic [15:0]      frame_count_q, frame_count_d;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    logic             par_q, par_d;
    logic             parity_out_q, parity_out_d;
`endif

    assign in_ready    = (state_q != SHIFT);
    assign shift_out   = shift_out_q;
    assign load_out    = load_out_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    assign parity_out  = parity_out_q;
`endif

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        cnt_d         = cnt_q;
        shift_out_d   = 1'b0;
        load_out_d    = 1'b0;
        busy_d        = 1'b0;
        frame_count_d = frame_count_q;
`ifdef SHIFT_SERIALIZER_PARITY_EN
        par_d         = par_q;
        parity_out_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE, LOAD: begin
                state_d = IDLE;
                if (state_q == LOAD) begin
                    frame_count_d = frame_count_q + 16'd1;
                end
                if (in_valid) begin
                    // Bit WIDTH-1 leaves on this edge; the buffer holds the rest.
                    state_d     = SHIFT;
                    data_d      = {in_data[WIDTH-2:0], 1'b0};
                    cnt_d       = '0;
                    shift_out_d = in_data[WIDTH-1];
                    busy_d      = 1'b1;
`ifdef SHIFT_SERIALIZER_PARITY_EN
                    par_d       = ^in_data;
`endif
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                if (cnt_q == LAST) begin
                    state_d    = LOAD;
                    load_out_d = 1'b1;
`ifdef SHIFT_SERIALIZER_PARITY_EN
                    parity_out_d = par_q;
`endif
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    shift_out_d = data_q[WIDTH-1];
                    data_d      = {data_q[WIDTH-2:0], 1'b0};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            data_q        <= '0;
            cnt_q         <= '0;
            shift_out_q   <= 1'b0;
            load_out_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            par_q         <= 1'b0;
            parity_out_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            cnt_q         <= cnt_d;
            shift_out_q   <= shift_out_d;
            load_out_q    <= load_out_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            par_q         <= par_d;
            parity_out_q  <= parity_out_d;
`endif
        end
    end

endmodule
